// File: rtl/video_pkg.sv
// Shared video definitions: per-axis timing struct, standard modes, TMDS control codes
// and the colour-bar palette helper used by video_timing_gen (pattern enabled by VTG_PATTERN_EN).
package video_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } video_timing_t;

    typedef struct packed {
        video_timing_t h;
        video_timing_t v;
    } video_mode_t;

    localparam video_mode_t TIMING_640x480 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2, bp: 33}
    };

    localparam video_mode_t TIMING_1280x720 = '{
        h: '{active: 1280, fp: 110, sync: 40, bp: 220},
        v: '{active: 720, fp: 5, sync: 5, bp: 20}
    };

    // TMDS control symbols indexed by {c1, c0} during blanking
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    // Bars run white, yellow, cyan, green, magenta, red, blue, black: each primary
    // is on when its selecting bit of the bar index is clear.
    function automatic logic [23:0] bar_rgb(input logic [2:0] bar);
        return {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    endfunction

endpackage

// File: rtl/video_mod_counter.sv
// Modulo-N up counter with enable and synchronous reset; wrap is high on the
// enabled cycle that takes the count from N-1 back to 0.
module video_mod_counter #(
    parameter int N = 800,
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator feeding TMDS encoder c0/c1/de plus pixel coordinates.
// Define VTG_PATTERN_EN to add registered r/g/b colour-bar outputs aligned with de.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = TIMING_640x480.h.active,
    parameter int H_FP     = TIMING_640x480.h.fp,
    parameter int H_SYNC   = TIMING_640x480.h.sync,
    parameter int H_BP     = TIMING_640x480.h.bp,
    parameter int V_ACTIVE = TIMING_640x480.v.active,
    parameter int V_FP     = TIMING_640x480.v.fp,
    parameter int V_SYNC   = TIMING_640x480.v.sync,
    parameter int V_BP     = TIMING_640x480.v.bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VTG_PATTERN_EN
    ,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $fatal(1, "video_timing_gen: every timing parameter must be >= 1");
    end
    if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
        $fatal(1, "video_timing_gen: H_ACTIVE must be a multiple of 8");
    end
    if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_width
        $fatal(1, "video_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end

    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          unused_v_wrap;

    video_mod_counter #(.N(H_TOTAL), .W(CW)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    // The line counter steps only on the pixel counter's wrap.
    video_mod_counter #(.N(V_TOTAL), .W(CW)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (v_cnt),
        .wrap  (unused_v_wrap)
    );

    logic active;
    logic h_in_sync;
    logic v_in_sync;

    always_comb begin
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
        v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hsync       <= h_in_sync ? HS_POL : ~HS_POL;
            vsync       <= v_in_sync ? VS_POL : ~VS_POL;
            de          <= active;
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            // Strobes are one clk wide even when the pixel clock enable is sparse.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VTG_PATTERN_EN
    localparam int            BAR_W    = H_ACTIVE / 8;
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    logic [CW-1:0] sub_cnt;
    logic [2:0]    bar_idx;

    // bar_idx/sub_cnt track h_cnt, restarting whenever h_cnt returns to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt <= '0;
            bar_idx <= '0;
        end else if (en) begin
            if (h_wrap) begin
                sub_cnt <= '0;
                bar_idx <= '0;
            end else if (sub_cnt == BAR_LAST) begin
                sub_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                sub_cnt <= sub_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r, g, b} <= '0;
        end else if (en) begin
            {r, g, b} <= active ? bar_rgb(bar_idx) : 24'h000000;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster (24x11 total);
// also covers the colour bars when VTG_PATTERN_EN is defined.
module tb_video_timing_gen;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 2;
    localparam int CW = 6;
    localparam bit HP = 1'b0, VP = 1'b0;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int W = 29 + 2 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] x, y;
    logic [7:0]    r, g, b;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HP), .VS_POL(VP), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
`ifdef VTG_PATTERN_EN
        , .r(r), .g(g), .b(b)
`endif
    );

`ifndef VTG_PATTERN_EN
    assign r = 8'h00;
    assign g = 8'h00;
    assign b = 8'h00;
`endif

    logic [W-1:0] act;
    assign act = {hsync, vsync, de, x, y, line_start, frame_start, r, g, b};

    // reference model: raster position as a single pixel index within the frame
    logic [23:0] bar_colour[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int           m_pos = 0;
    logic [W-1:0] m_out = '0;

    function automatic logic [W-1:0] reset_vec();
        return {!HP, !VP, 1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0, 24'h0};
    endfunction

    function automatic logic [W-1:0] exp_vec(input int pos);
        int h, v;
        logic d, hs, vs;
        logic [23:0] rgb;
        h = pos % HT;
        v = pos / HT;
        d = (h < HA) && (v < VA);
        hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HP : !HP;
        vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VP : !VP;
        rgb = 24'h0;
`ifdef VTG_PATTERN_EN
        if (d) rgb = bar_colour[h / (HA / 8)];
`endif
        return {hs, vs, d, CW'(h), CW'(v), (h == 0), (h == 0 && v == 0), rgb};
    endfunction

    task automatic model_step(input logic r_i, input logic e_i);
        if (r_i) begin
            m_out = reset_vec();
            m_pos = 0;
        end else if (e_i) begin
            m_out = exp_vec(m_pos);
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            m_out[25:24] = 2'b00;
        end
        exp_q.push_back(m_out);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rgb=%h expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rgb=%h",
                     name, act[W-1], act[W-2], act[W-3], act[W-4 -: CW], act[W-4-CW -: CW],
                     act[25], act[24], act[23:0], want[W-1], want[W-2], want[W-3],
                     want[W-4 -: CW], want[W-4-CW -: CW], want[25], want[24], want[23:0]);
        end
    endtask

    // driver: apply one clock of inputs, then score against the model
    task automatic cycle(input logic r_i, input logic e_i, input string name);
        rst = r_i;
        en = e_i;
        model_step(r_i, e_i);
        @(posedge clk);
        #1;
        check_vec(name, exp_q.pop_front());
    endtask

    typedef struct {
        int n;
        int x;
        int y;
        bit de, hs, vs, ls, fs;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input int xx, input int yy, input bit d, input bit hs,
                       input bit vs, input bit ls, input bit fs, input logic [23:0] rgb);
        vec_t v;
        v.n = n; v.x = xx; v.y = yy; v.de = d; v.hs = hs; v.vs = vs;
        v.ls = ls; v.fs = fs; v.rgb = rgb;
        tbl.push_back(v);
    endtask

    task automatic measure(input bit alt);
        int mult, fs_t[$], ls_cnt, de_cnt, hs_cnt, vs_cnt, hs_x, vs_y, vs_x, dbl;
        bit prev_fs, prev_ls;
        mult = alt ? 2 : 1;
        ls_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        hs_x = -1; vs_y = -1; vs_x = -1; dbl = 0;
        prev_fs = 1'b0; prev_ls = 1'b0;
        cycle(1'b1, 1'b0, "measure_reset");
        for (int i = 0; i < FRAME * mult + 4; i++) begin
            cycle(1'b0, alt ? (i % 2 == 0) : 1'b1, alt ? "sweep_alt" : "sweep");
            if (frame_start) fs_t.push_back(i);
            if ((prev_fs && frame_start) || (prev_ls && line_start)) dbl++;
            prev_fs = frame_start;
            prev_ls = line_start;
            if (i < FRAME * mult) begin
                if (line_start) ls_cnt++;
                if (de) de_cnt++;
                if (hsync == HP) hs_cnt++;
                if (vsync == VP) vs_cnt++;
                if (hsync == HP && hs_x < 0) hs_x = int'(x);
                if (vsync == VP && vs_y < 0) begin
                    vs_y = int'(y);
                    vs_x = int'(x);
                end
            end
        end
        check_int("frame_start_count", fs_t.size(), 2);
        if (fs_t.size() >= 2) check_int("frame_period", fs_t[1] - fs_t[0], FRAME * mult);
        check_int("strobe_one_clk", dbl, 0);
        check_int("line_start_count", ls_cnt, VT);
        check_int("de_cycles", de_cnt, HA * VA * mult);
        check_int("hsync_cycles", hs_cnt, HSW * VT * mult);
        check_int("vsync_cycles", vs_cnt, VSW * HT * mult);
        check_int("hsync_first_x", hs_x, HA + HFP);
        check_int("vsync_first_y", vs_y, VA + VFP);
        check_int("vsync_first_x", vs_x, 0);
    endtask

    initial begin
        logic [W-1:0] want;
        logic [23:0]  rgb_w;

        // reset state, with en high to show rst wins
        cycle(1'b1, 1'b1, "reset_state");
        check_vec("reset_const", reset_vec());

        // n enabled edges after reset: outputs describe counter position n-1
        add(1,   0,  0, 1, 1, 1, 1, 1, 24'hFFFFFF);
        add(2,   1,  0, 1, 1, 1, 0, 0, 24'hFFFFFF);
        add(3,   2,  0, 1, 1, 1, 0, 0, 24'hFFFF00);
        add(11, 10,  0, 1, 1, 1, 0, 0, 24'hFF0000);
        add(16, 15,  0, 1, 1, 1, 0, 0, 24'h000000);
        add(17, 16,  0, 0, 1, 1, 0, 0, 24'h000000);
        add(19, 18,  0, 0, 0, 1, 0, 0, 24'h000000);
        add(21, 20,  0, 0, 0, 1, 0, 0, 24'h000000);
        add(22, 21,  0, 0, 1, 1, 0, 0, 24'h000000);
        add(25,  0,  1, 1, 1, 1, 1, 0, 24'hFFFFFF);
        add(145, 0,  6, 0, 1, 1, 1, 0, 24'h000000);
        add(169, 0,  7, 0, 1, 0, 1, 0, 24'h000000);
        add(216, 23, 8, 0, 1, 0, 0, 0, 24'h000000);
        add(217, 0,  9, 0, 1, 1, 1, 0, 24'h000000);
        add(264, 23, 10, 0, 1, 1, 0, 0, 24'h000000);
        add(265, 0,  0, 1, 1, 1, 1, 1, 24'hFFFFFF);

        foreach (tbl[k]) begin
            cycle(1'b1, 1'b0, "table_reset");
            for (int i = 0; i < tbl[k].n; i++) cycle(1'b0, 1'b1, "table_run");
`ifdef VTG_PATTERN_EN
            rgb_w = tbl[k].rgb;
`else
            rgb_w = 24'h0;
`endif
            want = {tbl[k].hs, tbl[k].vs, tbl[k].de, CW'(tbl[k].x), CW'(tbl[k].y),
                    tbl[k].ls, tbl[k].fs, rgb_w};
            check_vec($sformatf("table_row%0d", k), want);
        end

        // strobe drops on a disabled cycle while other outputs hold
        cycle(1'b1, 1'b0, "hold_reset");
        cycle(1'b0, 1'b1, "hold_first");
        cycle(1'b0, 1'b0, "hold_en0");
        want = {!HP, !VP, 1'b1, {CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0, 24'h0};
`ifdef VTG_PATTERN_EN
        want[23:0] = 24'hFFFFFF;
`endif
        check_vec("hold_const", want);

        // mid-frame reset at x=10, y=3 abandons the frame
        cycle(1'b1, 1'b0, "mid_reset_pre");
        for (int i = 0; i < 3 * HT + 11; i++) cycle(1'b0, 1'b1, "mid_run");
        check_int("mid_pos_x", int'(x), 10);
        check_int("mid_pos_y", int'(y), 3);
        cycle(1'b1, 1'b1, "mid_reset");
        check_vec("mid_reset_const", reset_vec());
        cycle(1'b0, 1'b1, "mid_restart");
        check_int("mid_restart_fs", int'(frame_start), 1);

        measure(1'b0);
        measure(1'b1);

        // randomized enable and occasional reset against the model
        cycle(1'b1, 1'b0, "rand_reset");
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
